// File: rtl/bram_fifo_ctrl.sv
// FIFO controller for an external dual-port BRAM (port A writes, port B reads) with a register
// output queue that hides the BRAM read latency. Define BRAM_FIFO_COUNT_EN to add the o_count port.
module bram_fifo_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enq_valid,
   output logic                  o_enq_rdy,
   input  logic [DATA_WIDTH-1:0] i_enq_data,
   output logic                  o_deq_valid,
   input  logic                  i_deq_rdy,
   output logic [DATA_WIDTH-1:0] o_deq_data,
   output logic                  o_ena,
   output logic                  o_wea,
   output logic [ADDR_WIDTH-1:0] o_addra,
   output logic [DATA_WIDTH-1:0] o_dia,
   output logic                  o_enb,
   output logic                  o_web,
   output logic [ADDR_WIDTH-1:0] o_addrb,
   input  logic [DATA_WIDTH-1:0] i_dob
`ifdef BRAM_FIFO_COUNT_EN
   ,
   output logic [ADDR_WIDTH+1:0] o_count
`endif
);
   localparam int OQ_DEPTH = RD_LATENCY + 1;
   localparam int OQ_AW    = $clog2(OQ_DEPTH);
   localparam int OQ_CW    = $clog2(OQ_DEPTH + 1);

   logic [ADDR_WIDTH:0]   r_wptr;
   logic [ADDR_WIDTH:0]   r_rptr;
   logic [RD_LATENCY-1:0] r_rd_pipe;
   logic [DATA_WIDTH-1:0] r_oq_mem [OQ_DEPTH];
   logic [OQ_AW-1:0]      r_oq_head;
   logic [OQ_AW-1:0]      r_oq_tail;
   logic [OQ_CW-1:0]      r_oq_count;

   logic [ADDR_WIDTH:0]   w_mem_count;
   logic [OQ_CW-1:0]      w_inflight;
   logic [OQ_CW-1:0]      w_credit;
   logic                  w_enq_fire;
   logic                  w_deq_fire;
   logic                  w_rd_issue;
   logic                  w_capture;

   function automatic logic [OQ_AW-1:0] oq_next(input logic [OQ_AW-1:0] p);
      return (p == OQ_AW'(OQ_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // NOTE: give every always_comb output a default first so no path can infer a latch.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         w_inflight = w_inflight + OQ_CW'(r_rd_pipe[i]);
      end
   end

   assign w_mem_count = r_wptr - r_rptr;
   // mem_count never exceeds DEPTH, so its MSB alone marks the array as full
   assign o_enq_rdy   = !i_rst && !w_mem_count[ADDR_WIDTH];
   assign w_enq_fire  = i_enq_valid && o_enq_rdy;
   assign o_deq_valid = (r_oq_count != '0);
   assign w_deq_fire  = o_deq_valid && i_deq_rdy;
   assign w_credit    = r_oq_count + w_inflight;
   // A pop in this cycle frees an outq slot long before a read issued now can land in it
   assign w_rd_issue  = !i_rst && (w_mem_count != '0) &&
                        ((w_credit < OQ_CW'(OQ_DEPTH)) || w_deq_fire);
   assign w_capture   = r_rd_pipe[RD_LATENCY-1];

   assign o_ena      = w_enq_fire;
   assign o_wea      = w_enq_fire;
   assign o_addra    = r_wptr[ADDR_WIDTH-1:0];
   assign o_dia      = i_enq_data;
   assign o_enb      = w_rd_issue;
   assign o_web      = 1'b0;
   assign o_addrb    = r_rptr[ADDR_WIDTH-1:0];
   assign o_deq_data = r_oq_mem[r_oq_head];

`ifdef BRAM_FIFO_COUNT_EN
   localparam int CNT_W = ADDR_WIDTH + 2;
   assign o_count = CNT_W'(w_mem_count) + CNT_W'(w_inflight) + CNT_W'(r_oq_count);
`endif

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_rd_pipe  <= '0;
         r_oq_head  <= '0;
         r_oq_tail  <= '0;
         r_oq_count <= '0;
      end else begin
         if (w_enq_fire) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd_issue) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_rd_pipe <= (r_rd_pipe << 1) | RD_LATENCY'(w_rd_issue);
         if (w_capture) begin
            r_oq_tail <= oq_next(r_oq_tail);
         end
         if (w_deq_fire) begin
            r_oq_head <= oq_next(r_oq_head);
         end
         if (w_capture && !w_deq_fire) begin
            r_oq_count <= r_oq_count + 1'b1;
         end else if (!w_capture && w_deq_fire) begin
            r_oq_count <= r_oq_count - 1'b1;
         end
      end
   end

   // NOTE: outq storage is not reset; r_oq_count alone decides which slots hold live data.
   always_ff @(posedge i_clk) begin
      if (w_capture) begin
         r_oq_mem[r_oq_tail] <= i_dob;
      end
   end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: an RL=1 and an RL=2 instance, each with its own BRAM model,
// checked every cycle against a queue model of accepted-but-not-yet-dequeued words.
module tb_bram_fifo_ctrl;
   localparam int AW     = 4;
   localparam int DW     = 8;
   localparam int DEPTH  = 1 << AW;
   localparam int NI     = 2;
   localparam int NRAND  = 1000;

   typedef logic [DW-1:0] word_q_t [$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          enq_valid [NI];
   logic          enq_rdy   [NI];
   logic [DW-1:0] enq_data  [NI];
   logic          deq_valid [NI];
   logic          deq_rdy   [NI];
   logic [DW-1:0] deq_data  [NI];
   logic          ena       [NI];
   logic          wea       [NI];
   logic [AW-1:0] addra     [NI];
   logic [DW-1:0] dia       [NI];
   logic          enb       [NI];
   logic          web       [NI];
   logic [AW-1:0] addrb     [NI];
   logic [DW-1:0] dob       [NI];
`ifdef BRAM_FIFO_COUNT_EN
   logic [AW+1:0] count     [NI];
`endif

   for (genvar g = 0; g < NI; g++) begin : g_inst
      logic [DW-1:0] mem [DEPTH];
      logic [DW-1:0] rd_st0;
      logic [DW-1:0] rd_st1;

      bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(g + 1)) u_dut (
         .i_clk       (clk),
         .i_rst       (rst),
         .i_enq_valid (enq_valid[g]),
         .o_enq_rdy   (enq_rdy[g]),
         .i_enq_data  (enq_data[g]),
         .o_deq_valid (deq_valid[g]),
         .i_deq_rdy   (deq_rdy[g]),
         .o_deq_data  (deq_data[g]),
         .o_ena       (ena[g]),
         .o_wea       (wea[g]),
         .o_addra     (addra[g]),
         .o_dia       (dia[g]),
         .o_enb       (enb[g]),
         .o_web       (web[g]),
         .o_addrb     (addrb[g]),
         .i_dob       (dob[g])
`ifdef BRAM_FIFO_COUNT_EN
         ,
         .o_count     (count[g])
`endif
      );

      // BRAM2 model: RL=1 presents the read word the next cycle, RL=2 one cycle later
      always @(posedge clk) begin
         if (ena[g] && wea[g]) mem[addra[g]] <= dia[g];
         if (enb[g]) rd_st0 <= mem[addrb[g]];
         rd_st1 <= rd_st0;
      end
      assign dob[g] = (g == 0) ? rd_st0 : rd_st1;
   end

   word_q_t       exp_q      [NI];
   int            wr_n       [NI];
   int            rd_n       [NI];
   int            acc_n      [NI];
   int            pop_n      [NI];
   int            base       [NI];
   int            pb         [NI];
   int            first_pop  [NI];
   int            last_pop   [NI];
   logic          prev_stall [NI];
   logic [DW-1:0] prev_data  [NI];
   logic          obs_enb    [NI];
   logic          obs_dv     [NI];
   logic          obs_rdy    [NI];
   logic          obs_pop    [NI];
   logic [DW-1:0] rnd        [NRAND];
   logic          rst_q;
   int            n_checks = 0;
   int            n_pass   = 0;
   int            cyc      = 0;

   task automatic check(input string tag, input int inst, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s (RL=%0d, cycle %0d): got 0x%0h, expected 0x%0h",
                    tag, inst + 1, cyc, got, exp);
   endtask

   // One clock cycle: sample at the falling edge, check against the model, then advance.
   task automatic step();
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         int   occ;
         int   cap;
         logic e_fire;
         occ        = exp_q[g].size();
         cap        = DEPTH + g + 2;
         e_fire     = enq_valid[g] && enq_rdy[g];
         obs_enb[g] = enb[g];
         obs_dv[g]  = deq_valid[g];
         obs_rdy[g] = enq_rdy[g];
         obs_pop[g] = 1'b0;
         check("web_low", g, 32'(web[g]), 32'd0);
         if (rst) begin
            check("rst_enq_rdy", g, 32'(enq_rdy[g]), 32'd0);
            check("rst_ena", g, 32'(ena[g]), 32'd0);
            check("rst_enb", g, 32'(enb[g]), 32'd0);
            if (rst_q) check("rst_deq_valid", g, 32'(deq_valid[g]), 32'd0);
            exp_q[g].delete();
            wr_n[g]       = 0;
            rd_n[g]       = 0;
            prev_stall[g] = 1'b0;
         end else begin
`ifdef BRAM_FIFO_COUNT_EN
            check("count", g, 32'(count[g]), occ);
`endif
            check("ena", g, 32'(ena[g]), 32'(e_fire));
            check("wea", g, 32'(wea[g]), 32'(e_fire));
            if (occ < DEPTH) check("enq_rdy_space", g, 32'(enq_rdy[g]), 32'd1);
            if (occ == cap) check("enq_rdy_full", g, 32'(enq_rdy[g]), 32'd0);
            if (prev_stall[g]) begin
               check("hold_valid", g, 32'(deq_valid[g]), 32'd1);
               check("hold_data", g, 32'(deq_data[g]), 32'(prev_data[g]));
            end
            if (deq_valid[g]) begin
               if (occ == 0) begin
                  check("underflow", g, 32'(deq_valid[g]), 32'd0);
               end else begin
                  check("deq_data", g, 32'(deq_data[g]), 32'(exp_q[g][0]));
                  if (deq_rdy[g]) begin
                     void'(exp_q[g].pop_front());
                     pop_n[g]++;
                     obs_pop[g] = 1'b1;
                  end
               end
            end
            if (enb[g]) begin
               check("rd_after_wr", g, 32'(rd_n[g] < wr_n[g]), 32'd1);
               check("addrb", g, 32'(addrb[g]), rd_n[g] % DEPTH);
               rd_n[g]++;
            end
            if (e_fire) begin
               check("addra", g, 32'(addra[g]), wr_n[g] % DEPTH);
               check("dia", g, 32'(dia[g]), 32'(enq_data[g]));
               if (enb[g]) check("no_collision", g, 32'(addra[g] != addrb[g]), 32'd1);
               exp_q[g].push_back(enq_data[g]);
               wr_n[g]++;
               acc_n[g]++;
            end
            prev_stall[g] = deq_valid[g] && !deq_rdy[g];
            prev_data[g]  = deq_data[g];
         end
      end
      rst_q = rst;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      rst = 1'b1;
      for (int g = 0; g < NI; g++) begin
         enq_valid[g]  = 1'b1;
         enq_data[g]   = 8'hFF;
         deq_rdy[g]    = 1'b0;
         prev_stall[g] = 1'b0;
         wr_n[g] = 0; rd_n[g] = 0; acc_n[g] = 0; pop_n[g] = 0;
      end
      for (int i = 0; i < NRAND; i++) rnd[i] = DW'($urandom);
      @(posedge clk);
      #1;
      rst_q = 1'b1;
      repeat (3) step();

      rst = 1'b0;
      for (int g = 0; g < NI; g++) enq_valid[g] = 1'b0;
      step();
      for (int g = 0; g < NI; g++) begin
         check("post_rst_rdy", g, 32'(obs_rdy[g]), 32'd1);
         check("post_rst_dv", g, 32'(obs_dv[g]), 32'd0);
      end

      // Single word into an empty FIFO: read issues next cycle, valid after RL+2 cycles
      for (int g = 0; g < NI; g++) begin
         enq_valid[g] = 1'b1;
         enq_data[g]  = 8'hA5;
      end
      step();
      for (int g = 0; g < NI; g++) begin
         check("lat_enb", g, 32'(obs_enb[g]), 32'd0);
         enq_valid[g] = 1'b0;
      end
      for (int k = 1; k <= 5; k++) begin
         step();
         for (int g = 0; g < NI; g++) begin
            check("lat_enb", g, 32'(obs_enb[g]), 32'(k == 1));
            check("lat_deq_valid", g, 32'(obs_dv[g]), 32'(k >= g + 3));
         end
      end
      for (int g = 0; g < NI; g++) deq_rdy[g] = 1'b1;
      step();
      for (int g = 0; g < NI; g++) deq_rdy[g] = 1'b0;
      step();

      // Fill to capacity with the consumer stalled, then drain in order
      for (int g = 0; g < NI; g++) begin
         base[g]      = acc_n[g];
         enq_valid[g] = 1'b1;
      end
      repeat (30) begin
         for (int g = 0; g < NI; g++) enq_data[g] = DW'(acc_n[g] - base[g]);
         step();
      end
      for (int g = 0; g < NI; g++) begin
         check("fill_count", g, acc_n[g] - base[g], DEPTH + g + 2);
         check("fill_rdy_low", g, 32'(obs_rdy[g]), 32'd0);
         enq_valid[g] = 1'b0;
         deq_rdy[g]   = 1'b1;
         pb[g]        = pop_n[g];
      end
      repeat (30) step();
      for (int g = 0; g < NI; g++) check("drain_count", g, pop_n[g] - pb[g], DEPTH + g + 2);

      // Streaming: 100 words with both sides always ready, one dequeue per cycle once primed
      for (int g = 0; g < NI; g++) begin
         base[g] = acc_n[g]; pb[g] = pop_n[g];
         first_pop[g] = -1; last_pop[g] = -1;
      end
      for (int t = 0; t < 400; t++) begin
         for (int g = 0; g < NI; g++) begin
            enq_valid[g] = (acc_n[g] - base[g]) < 100;
            enq_data[g]  = DW'(acc_n[g] - base[g]);
         end
         step();
         for (int g = 0; g < NI; g++) begin
            if (obs_pop[g]) begin
               if (first_pop[g] < 0) first_pop[g] = cyc;
               last_pop[g] = cyc;
            end
         end
         if ((pop_n[0] - pb[0]) >= 100 && (pop_n[1] - pb[1]) >= 100) break;
      end
      for (int g = 0; g < NI; g++) begin
         check("stream_words", g, pop_n[g] - pb[g], 32'd100);
         check("stream_no_gaps", g, last_pop[g] - first_pop[g], 32'd99);
      end

      // Random valid/ready traffic
      for (int g = 0; g < NI; g++) begin
         base[g] = acc_n[g]; pb[g] = pop_n[g];
      end
      for (int t = 0; t < 20000; t++) begin
         for (int g = 0; g < NI; g++) begin
            int idx;
            idx          = acc_n[g] - base[g];
            enq_valid[g] = (idx < NRAND) && ($urandom_range(0, 3) != 0);
            enq_data[g]  = (idx < NRAND) ? rnd[idx] : 8'h00;
            deq_rdy[g]   = $urandom_range(0, 1) == 1;
         end
         step();
         if ((pop_n[0] - pb[0]) >= NRAND && (pop_n[1] - pb[1]) >= NRAND) break;
      end
      for (int g = 0; g < NI; g++) check("rand_words", g, pop_n[g] - pb[g], NRAND);

      // Reset with words stored and reads in flight; stale BRAM data must not surface
      for (int g = 0; g < NI; g++) begin
         base[g]    = acc_n[g];
         deq_rdy[g] = 1'b0;
      end
      repeat (10) begin
         for (int g = 0; g < NI; g++) begin
            enq_valid[g] = (acc_n[g] - base[g]) < 5;
            enq_data[g]  = DW'(8'h50 + acc_n[g] - base[g]);
         end
         if ((acc_n[0] - base[0]) >= 5 && (acc_n[1] - base[1]) >= 5) break;
         step();
      end
      for (int g = 0; g < NI; g++) enq_valid[g] = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (4) begin
         step();
         for (int g = 0; g < NI; g++) begin
            check("flush_dv", g, 32'(obs_dv[g]), 32'd0);
            check("flush_rdy", g, 32'(obs_rdy[g]), 32'd1);
         end
      end
      for (int g = 0; g < NI; g++) begin
         enq_valid[g] = 1'b1;
         enq_data[g]  = 8'h3C;
         pb[g]        = pop_n[g];
      end
      step();
      for (int g = 0; g < NI; g++) begin
         enq_valid[g] = 1'b0;
         deq_rdy[g]   = 1'b1;
      end
      repeat (8) step();
      for (int g = 0; g < NI; g++) check("post_flush_words", g, pop_n[g] - pb[g], 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
